qamdemod: RTL and testbench
===========================

Name: qamdemod

Overview:
- Hard-decision QAM demodulator. Inverse of qammod: slices received I/Q samples back into symbol bit groups.
- Sits after the channel/equalizer in the receive chain, feeding the bit deserializer.
- Per axis: binary-reflected Gray decode; I bits in the MSBs, the same mapping qammod uses.
- Three-stage pipeline with valid/ready flow control and a saturating counter of clipped symbols.

Parameters:
- MODULATION_ORDER, 64, square QAM order M (4, 16, 64, 256). K = sqrt(M) levels per axis; B = log2(M)/2 bits per axis.
- IQ_WIDTH, 12, width of signed two's-complement I/Q input samples.
- FRAC_BITS, 4, LSBs per unit amplitude. Ideal level k sits at (2k-(K-1))*2^FRAC_BITS.
- Elaboration error unless FRAC_BITS+log2(K)+1 <= IQ_WIDTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_dv  input  1  input sample valid
- i_ready  output  1  block can accept a sample this cycle
- i_i  input  IQ_WIDTH  signed in-phase sample
- i_q  input  IQ_WIDTH  signed quadrature sample
- o_dv  output  1  output symbol valid
- o_ready  input  1  downstream accepts symbol
- o_s  output  2B  decoded symbol; [2B-1:B] = I bits, [B-1:0] = Q bits
- i_sat_clr  input  1  synchronous clear of o_sat_cnt
- o_sat_cnt  output  16  saturating count of accepted symbols with any axis outside the decision range

Behaviour:
- Reset (rst low, asynchronous assert, synchronous deassert by the system): all stage valids 0, o_dv 0, o_s 0, o_sat_cnt 0. i_ready is 1 on the first cycle after reset release.
- Transfers: input transfer when i_dv & i_ready; output transfer when o_dv & o_ready.
- S1 registers i_i/i_q.
- S2, per axis:
  - u = x + K*2^FRAC_BITS, computed at IQ_WIDTH+2 signed.
  - k = u >> (FRAC_BITS+1) (arithmetic), clamped to [0, K-1].
  - sat flag = (u < 0) | (u >= 2K*2^FRAC_BITS).
- S3, per axis: g = k ^ (k>>1); o_s = {g_i, g_q}. Registers the OR of both sat flags.
- Latency: 3 cycles from input transfer to o_dv, with no backpressure.
- Throughput: one symbol per cycle.
- Backpressure:
  - Each stage advances when its successor is empty or advancing.
  - Bubbles collapse.
  - i_ready = !S1_valid | S1_advances.
  - o_dv/o_s stay stable while o_dv & !o_ready.
  - No symbol is lost or duplicated.
- Decision boundaries lie at even unit amplitudes. A sample exactly on a boundary takes the upper level (floor rule).
- o_sat_cnt:
  - Increments on each output transfer whose symbol carries the sat flag.
  - Holds at 0xFFFF.
  - i_sat_clr has priority: when coincident with an increment, the result is 0.
- Reset mid-stream flushes all stages. In-flight symbols are discarded.

Test Plan (M=16, IQ_WIDTH=12, FRAC_BITS=4, so levels are -48, -16, 16, 48):
- Ideal points, o_ready=1: (i,q)=(48,-48) -> o_s=4'b1000; (16,-16) -> 4'b1101; (-16,16) -> 4'b0111; (-48,48) -> 4'b0010. Each appears 3 cycles after input; o_sat_cnt stays 0.
- Boundaries: i=0 -> I bits 11 (k=2); i=-1 -> 01 (k=1); i=32 -> 10 (k=3); i=31 -> 11.
- Saturation:
  - (2047,-2048) -> o_s=4'b1000, o_sat_cnt=1.
  - i=64 counts as saturated; i=63 does not.
  - Pulse i_sat_clr on the same cycle as a saturated output transfer -> o_sat_cnt=0.
- Backpressure:
  - Stream 10 random samples with o_ready held low for 5 cycles mid-stream.
  - i_ready drops once 3 symbols are buffered.
  - Output sequence equals the reference model exactly, in order.
- Random i_dv/o_ready toggling over 10k samples across M=4/16/64/256 -> scoreboard matches the golden slicer; verify qammod -> qamdemod loopback returns the original symbols.
- Assert rst with 2 symbols in flight -> o_dv=0, o_sat_cnt=0 immediately; the next input after release emerges after 3 cycles.

Source files
------------

// File: rtl/qamdemod.sv
// qamdemod: three-stage hard-decision square-QAM slicer with Gray decode, valid/ready flow and a clipped-symbol counter.
//   clk, rst (async active-low)
//   i_dv/i_ready/i_i/i_q      : signed I/Q sample input handshake
//   o_dv/o_ready/o_s          : decoded symbol output handshake, o_s = {I Gray bits, Q Gray bits}
//   i_sat_clr/o_sat_cnt       : clear / saturating count of delivered symbols that fell outside the decision range
module qamdemod #(
  parameter int MODULATION_ORDER = 64,
  parameter int IQ_WIDTH = 12,
  parameter int FRAC_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dv,
  output logic i_ready,
  input  logic signed [IQ_WIDTH-1:0] i_i,
  input  logic signed [IQ_WIDTH-1:0] i_q,
  output logic o_dv,
  input  logic o_ready,
  output logic [$clog2(MODULATION_ORDER)-1:0] o_s,
  input  logic i_sat_clr,
  output logic [15:0] o_sat_cnt
);
  localparam int B = $clog2(MODULATION_ORDER) / 2;
  localparam int W = IQ_WIDTH + 2;
  localparam logic [W-1:0] OFF = W'((2 ** B) << FRAC_BITS);
  if (FRAC_BITS + B + 1 > IQ_WIDTH - 1) begin : g_bad_width
    $error("qamdemod: FRAC_BITS + log2(K) + 1 must not exceed IQ_WIDTH - 1");
  end
  if (4 ** B != MODULATION_ORDER) begin : g_bad_order
    $error("qamdemod: MODULATION_ORDER must be an even power of two");
  end
  // Shift the sample so level 0 starts at u = 0; each level then spans 2^(FRAC_BITS+1).
  // Anything above the top level shows up as nonzero bits above the level index.
  function automatic logic [B:0] slice(input logic [IQ_WIDTH-1:0] x);
    logic [W-1:0] u;
    logic hi;
    u = {{2{x[IQ_WIDTH-1]}}, x} + OFF;
    hi = |u[W-2:B+FRAC_BITS+1];
    return {u[W-1] | hi, u[W-1] ? {B{1'b0}} : hi ? {B{1'b1}} : u[B+FRAC_BITS:FRAC_BITS+1]};
  endfunction
  logic v1, v2, sat2, sat3, en2, en3;
  logic [IQ_WIDTH-1:0] x1_i, x1_q;
  logic [B-1:0] k_i, k_q;
  logic [B:0] sl_i, sl_q;
  assign sl_i = slice(x1_i);
  assign sl_q = slice(x1_q);
  assign en3 = !o_dv | o_ready;
  assign en2 = !v2 | en3;
  assign i_ready = !v1 | en2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      o_dv <= 1'b0;
      x1_i <= '0;
      x1_q <= '0;
      k_i <= '0;
      k_q <= '0;
      sat2 <= 1'b0;
      sat3 <= 1'b0;
      o_s <= '0;
      o_sat_cnt <= '0;
    end else begin
      if (i_ready) v1 <= i_dv;
      if (i_ready && i_dv) begin
        x1_i <= i_i;
        x1_q <= i_q;
      end
      if (en2) v2 <= v1;
      if (en2 && v1) begin
        k_i <= sl_i[B-1:0];
        k_q <= sl_q[B-1:0];
        sat2 <= sl_i[B] | sl_q[B];
      end
      if (en3) o_dv <= v2;
      if (en3 && v2) begin
        o_s <= {k_i ^ (k_i >> 1), k_q ^ (k_q >> 1)};
        sat3 <= sat2;
      end
      o_sat_cnt <= i_sat_clr ? '0 : (o_dv && o_ready && sat3 && !(&o_sat_cnt)) ? o_sat_cnt + 16'd1 : o_sat_cnt;
    end
  end
endmodule

// File: tb/tb_qamdemod.sv
// tb_qamdemod: randomized scoreboard bench for qamdemod at M=16 with directed literal checks.
module tb_qamdemod;
  localparam int M = 16;
  localparam int IQW = 12;
  localparam int FB = 4;
  localparam int K = 4;
  localparam int B = 2;
  logic clk = 0, rst = 0, i_dv = 0, o_ready = 1, i_sat_clr = 0;
  logic i_ready, o_dv;
  logic signed [IQW-1:0] i_i = 0, i_q = 0;
  logic [2*B-1:0] o_s;
  logic [15:0] o_sat_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  qamdemod #(.MODULATION_ORDER(M), .IQ_WIDTH(IQW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .i_dv(i_dv), .i_ready(i_ready), .i_i(i_i), .i_q(i_q),
    .o_dv(o_dv), .o_ready(o_ready), .o_s(o_s), .i_sat_clr(i_sat_clr), .o_sat_cnt(o_sat_cnt)
  );
  typedef struct packed {logic [3:0] s; logic sat; logic [3:0] orig; logic lb;} exp_t;
  exp_t sb[$];
  int mcnt = 0;
  bit prev_stall = 0;
  logic [3:0] prev_s = 0;
  logic [3:0] cur_orig = 0;
  logic cur_lb = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Golden slicer: nearest ideal level by floor division, clamped, then Gray code.
  function automatic logic [2:0] axis(input int x);
    int u, k;
    logic s;
    u = x + K * (1 << FB);
    s = 0;
    if (u < 0) begin
      k = 0;
      s = 1;
    end else begin
      k = u / (2 << FB);
      if (k > K - 1) begin
        k = K - 1;
        s = 1;
      end
    end
    return {s, B'(k ^ (k >> 1))};
  endfunction
  function automatic logic [4:0] model(input int x, input int y);
    logic [2:0] a, b;
    a = axis(x);
    b = axis(y);
    return {a[2] | b[2], a[1:0], b[1:0]};
  endfunction
  // qammod level for a Gray-coded axis value.
  function automatic int lvl(input logic [1:0] g);
    int k, b;
    k = 0;
    b = 0;
    for (int i = B - 1; i >= 0; i--) begin
      b = b ^ int'(g[i]);
      k = k | (b << i);
    end
    return (2 * k - (K - 1)) * (1 << FB);
  endfunction
  always @(negedge clk) begin
    exp_t f;
    logic [4:0] e;
    bit so;
    so = 0;
    if (!rst) begin
      sb.delete();
      mcnt = 0;
      prev_stall = 0;
    end else begin
      chk("sat_cnt", 32'(o_sat_cnt), 32'(mcnt));
      if (prev_stall) chk("stall_hold", {o_dv, o_s}, {1'b1, prev_s});
      if (i_dv && i_ready) begin
        e = model(i_i, i_q);
        sb.push_back('{e[3:0], e[4], cur_orig, cur_lb});
      end
      if (o_dv && o_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          f = sb.pop_front();
          chk("o_s", o_s, f.s);
          if (f.lb) chk("loopback", o_s, f.orig);
          so = f.sat;
        end
      end
      if (i_sat_clr) mcnt = 0;
      else if (o_dv && o_ready && so && mcnt < 65535) mcnt++;
      prev_stall = o_dv && !o_ready;
      prev_s = o_s;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic directed(input string nm, input int x, input int y, input logic [3:0] es, input int ecnt, input bit clr);
    cyc();
    i_i = IQW'(x);
    i_q = IQW'(y);
    i_dv = 1;
    cur_lb = 0;
    cyc();
    i_dv = 0;
    cyc();
    chk({nm, "_early"}, o_dv, 0);
    cyc();
    chk({nm, "_dv"}, o_dv, 1);
    chk({nm, "_s"}, o_s, es);
    i_sat_clr = clr;
    cyc();
    i_sat_clr = 0;
    chk({nm, "_cnt"}, 32'(o_sat_cnt), 32'(ecnt));
    chk({nm, "_drained"}, o_dv, 0);
  endtask
  task automatic new_sample(input bit allow_lb);
    int nx, ny;
    logic [3:0] s;
    if (allow_lb && $urandom_range(1) == 1) begin
      s = 4'($urandom);
      nx = int'($urandom_range(30)) - 15;
      ny = int'($urandom_range(30)) - 15;
      i_i = IQW'(lvl(s[3:2]) + nx);
      i_q = IQW'(lvl(s[1:0]) + ny);
      cur_orig = s;
      cur_lb = 1;
    end else begin
      i_i = IQW'($urandom);
      i_q = IQW'($urandom);
      cur_lb = 0;
    end
  endtask
  initial begin
    int sent, n, c0;
    bit acc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", o_dv, 0);
    chk("rst_s", o_s, 0);
    chk("rst_cnt", 32'(o_sat_cnt), 0);
    @(negedge clk);
    rst = 1;
    cyc();
    chk("ready_after_rst", i_ready, 1);
    directed("p48m48", 48, -48, 4'b1000, 0, 0);
    directed("p16m16", 16, -16, 4'b1101, 0, 0);
    directed("m16p16", -16, 16, 4'b0111, 0, 0);
    directed("m48p48", -48, 48, 4'b0010, 0, 0);
    directed("bnd_0", 0, 0, 4'b1111, 0, 0);
    directed("bnd_m1", -1, 0, 4'b0111, 0, 0);
    directed("bnd_32", 32, 0, 4'b1011, 0, 0);
    directed("bnd_31", 31, 0, 4'b1111, 0, 0);
    directed("sat_ext", 2047, -2048, 4'b1000, 1, 0);
    directed("sat_64", 64, 0, 4'b1011, 2, 0);
    directed("nosat_63", 63, 0, 4'b1011, 2, 0);
    directed("sat_clr", -2048, 0, 4'b0011, 0, 1);
    // Backpressure: output stalled for the first 5 cycles of a 10-sample stream.
    o_ready = 0;
    new_sample(1);
    i_dv = 1;
    sent = 0;
    n = 0;
    while (sent < 10 && n < 200) begin
      @(negedge clk);
      acc = i_dv && i_ready;
      cyc();
      n++;
      if (acc) begin
        sent++;
        new_sample(1);
      end
      if (n == 2) chk("bp_ready_2", i_ready, 1);
      if (n == 3) chk("bp_ready_full", i_ready, 0);
      if (n == 5) o_ready = 1;
    end
    i_dv = 0;
    chk("bp_sent", 32'(sent), 10);
    repeat (6) cyc();
    chk("bp_drained", 32'(sb.size()), 0);
    // Random handshake toggling.
    sent = 0;
    n = 0;
    new_sample(1);
    while (sent < 10000 && n < 60000) begin
      i_dv = $urandom_range(3) != 0;
      o_ready = $urandom_range(3) != 0;
      i_sat_clr = $urandom_range(199) == 0;
      @(negedge clk);
      acc = i_dv && i_ready;
      cyc();
      n++;
      if (acc) begin
        sent++;
        new_sample(1);
      end
    end
    i_dv = 0;
    o_ready = 1;
    i_sat_clr = 0;
    chk("rand_sent", 32'(sent), 10000);
    repeat (6) cyc();
    chk("rand_drained", 32'(sb.size()), 0);
    c0 = mcnt;
    directed("sat_pre_rst", 2047, 2047, 4'b1010, c0 + 1, 0);
    // Reset with two symbols in flight.
    i_i = 16;
    i_q = 16;
    i_dv = 1;
    cyc();
    i_i = -16;
    cyc();
    i_dv = 0;
    rst = 0;
    #1;
    chk("midrst_dv", o_dv, 0);
    chk("midrst_cnt", 32'(o_sat_cnt), 0);
    repeat (2) cyc();
    @(negedge clk);
    rst = 1;
    repeat (4) cyc();
    chk("midrst_flushed", o_dv, 0);
    directed("post_rst", 48, -48, 4'b1000, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
